ej32_mseq: RTL and testbench
============================

EJ32_MSEQ -- requirements
Module: ej32_mseq

Interface
REQ-001 The block SHALL provide these ports; the clock is clk, and the reset is rst, asynchronous and active-low:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- f_req  in  1  fetch request, held until f_ack
- f_ai  in  `IU  fetch byte address
- f_ack  out  1  one-cycle fetch completion pulse
- f_vo  out  8  fetched byte, valid with f_ack
- d_req  in  1  data request, held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_len  in  2  00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes
- d_ai  in  `IU  data start byte address
- d_vi  in  32  store value, right-justified
- d_ack  out  1  one-cycle data completion pulse
- d_vo  out  32  load value, zero-extended, valid with d_ack
- m_we  out  1  byte-memory write enable
- m_ai  out  `IU  byte-memory address
- m_vi  out  8  byte-memory write data
- m_vo  in  8  byte-memory read data, valid one cycle after m_ai (synchronous read)
- busy  out  1  a transaction is in progress

Function
REQ-002 The block SHALL share one 8-bit memory port between the fetch and data requesters, with one transaction at a time.
REQ-003 The FSM SHALL have states IDLE, FETCH, DRD, DWR and DONE.
REQ-004 In IDLE, arbitration SHALL be evaluated every cycle; a grant SHALL latch the address, length, direction and store value, and SHALL move the FSM to FETCH, DRD or DWR on the next edge.
REQ-005 In FETCH, the block SHALL drive m_ai = f_ai for one cycle; the next cycle (DONE) SHALL capture m_vo into f_vo and pulse f_ack; the fetch latency from grant to f_ack SHALL be 2 cycles.
REQ-006 In DRD, the block SHALL issue n = 1, 2 or 4 consecutive addresses a, a+1, ... one per cycle.
- Each returned byte SHALL shift into d_vo most-significant first (big-endian), with bytes arriving one cycle after their address.
- d_ack SHALL pulse in DONE; load latency from grant SHALL be n+1 cycles.
REQ-007 In DWR, the block SHALL assert m_we for n consecutive cycles, writing byte n-1 (most significant) of d_vi first to address a, down to byte 0 at a+n-1.
- d_ack SHALL pulse in DONE; store latency from grant SHALL be n+1 cycles.
REQ-008 DONE SHALL last exactly one cycle and then return to IDLE; a waiting request SHALL therefore be granted no sooner than the cycle after the ack.
REQ-009 Address increments SHALL wrap modulo 2^`IU.
REQ-010 m_we SHALL be 0 in every state other than DWR.
REQ-011 m_ai and m_vi SHALL hold their last value when idle.
REQ-012 busy SHALL be 1 in every state other than IDLE.
REQ-013 Deassertion of a request mid-transaction SHALL NOT abort it; the transaction SHALL complete and its ack SHALL still pulse.
REQ-014 Request inputs other than f_req and d_req SHALL be sampled only at grant.
REQ-015 f_vo and d_vo SHALL hold their values until the next ack of the same port.

Reset
REQ-016 Assertion of rst (low) SHALL immediately force IDLE and set these outputs to 0: f_ack, d_ack, m_we, busy, f_vo, d_vo, m_ai, m_vi; the round-robin pointer SHALL reset to favour fetch.
REQ-017 Reset asserted mid-transaction SHALL abort it with no ack, and m_we SHALL drop asynchronously.
REQ-018 After rst deasserts, the first grant SHALL occur no earlier than the first rising edge.

Configuration
REQ-019 The block SHALL support the macro MSEQ_RR_EN.
- Defined: simultaneous f_req and d_req SHALL be granted alternately by a one-bit last-grant pointer, updated at each grant.
- Undefined: the data request SHALL always win over the fetch request, and the pointer logic SHALL be absent.
- A single request SHALL be granted immediately in both modes.

Structure
REQ-020 The ej32_pkg package SHALL hold the mseq_state_t enum (IDLE, FETCH, DRD, DWR, DONE) and the d_len encoding constants; the `IU width SHALL come from eJ32.vh.
REQ-021 The arbitration decision SHALL be a sub-module ej32_arb2 (inputs f_req, d_req, en; outputs gnt_f, gnt_d), with its pointer kept inside under MSEQ_RR_EN.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Fetch: memory[0x0010] = 0xA5; f_req, f_ai = 0x0010 -> f_ack 2 cycles after grant, f_vo = 0xA5, m_we never 1.
- Word load: memory[0x20..0x23] = 12 34 56 78; d_len = 10 -> d_ack at cycle 5, d_vo = 0x12345678.
- Halfword store: d_vi = 0xCAFEBEEF, d_len = 01, d_ai = 0x40 -> writes 0xBE@0x40 then 0xEF@0x41 on 2 consecutive cycles; d_ack 3 cycles after grant.
- Contention: f_req and d_req held continuously -> with MSEQ_RR_EN, grants F, D, F, D...; without it, all D grants until d_req drops.
- Wrap: 4-byte load at the top address 2^`IU-2 -> reads addresses top-2, top-1, 0, 1.
- Reset: rst low during cycle 2 of a 4-byte store -> m_we = 0 immediately, no d_ack, busy = 0, and the next request completes normally.

Source files
------------

// File: rtl/ej32_pkg.sv
// Shared types for the eJ32 memory sequencer: FSM states, d_len encodings, address width.
`include "eJ32.vh"
package ej32_pkg;
    localparam int IU_W = `IU;

    typedef enum logic [2:0] {IDLE, FETCH, DRD, DWR, DONE} mseq_state_t;

    localparam logic [1:0] DLEN_B = 2'b00;
    localparam logic [1:0] DLEN_H = 2'b01;
    localparam logic [1:0] DLEN_W = 2'b10;

    // Number of bytes minus one, so the sequencer counts down to zero.
    function automatic logic [1:0] dlen_last(input logic [1:0] len);
        case (len)
            DLEN_B:         return 2'd0;
            DLEN_H:         return 2'd1;
            DLEN_W, 2'b11:  return 2'd3;
            default:        return 2'd3;
        endcase
    endfunction
endpackage

// File: rtl/eJ32.vh
`ifndef EJ32_VH
`define EJ32_VH
`define IU 16
`endif

// File: rtl/ej32_arb2.sv
// Two-way fetch/data arbiter; combinational grant, only meaningful while en is high.
// MSEQ_RR_EN: alternate on contention via a last-grant pointer, else data always wins.
module ej32_arb2 (
`ifdef MSEQ_RR_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic f_req,
    input  logic d_req,
    input  logic en,
    output logic gnt_f,
    output logic gnt_d
);
`ifdef MSEQ_RR_EN
    logic r_last_d;

    // Reset value 1 means "data went last", so fetch is favoured first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last_d <= 1'b1;
        end else if (gnt_f) begin
            r_last_d <= 1'b0;
        end else if (gnt_d) begin
            r_last_d <= 1'b1;
        end
    end

    assign gnt_f = en & f_req & (~d_req | r_last_d);
    assign gnt_d = en & d_req & ~gnt_f;
`else
    assign gnt_d = en & d_req;
    assign gnt_f = en & f_req & ~d_req;
`endif
endmodule

// File: rtl/ej32_mseq.sv
// Shares one byte-wide synchronous memory between fetch and data ports (MSEQ_RR_EN selects round-robin).
// Latency: fetch 2, load/store n+1 cycles from grant; requests wait while busy, one transaction at a time.
`include "eJ32.vh"
module ej32_mseq
    import ej32_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            f_req,
    input  logic [`IU-1:0]  f_ai,
    output logic            f_ack,
    output logic [7:0]      f_vo,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [1:0]      d_len,
    input  logic [`IU-1:0]  d_ai,
    input  logic [31:0]     d_vi,
    output logic            d_ack,
    output logic [31:0]     d_vo,
    output logic            m_we,
    output logic [`IU-1:0]  m_ai,
    output logic [7:0]      m_vi,
    input  logic [7:0]      m_vo,
    output logic            busy
);
    mseq_state_t     r_state, w_nxt;
    logic            r_is_f, r_is_wr, r_rd_pend;
    logic [1:0]      r_left;
    logic [IU_W-1:0] r_m_ai;
    logic [7:0]      r_m_vi, r_f_vo;
    logic [23:0]     r_wsh, r_acc;
    logic [31:0]     r_d_vo;
    logic            w_gnt_f, w_gnt_d, w_last;
    logic [1:0]      w_glast;
    logic [31:0]     w_sv_al, w_ld;

    ej32_arb2 u_arb (
`ifdef MSEQ_RR_EN
        .clk   (clk),
        .rst   (rst),
`endif
        .f_req (f_req),
        .d_req (d_req),
        .en    (r_state == IDLE),
        .gnt_f (w_gnt_f),
        .gnt_d (w_gnt_d)
    );

    assign w_glast = dlen_last(d_len);
    // Left-align the store value so the most significant live byte goes out first.
    assign w_sv_al = d_vi << {(2'd3 - w_glast), 3'b000};
    assign w_last  = (r_left == 2'd0);
    assign w_ld    = {r_acc, m_vo};

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_gnt_f) begin
                    w_nxt = FETCH;
                end else if (w_gnt_d) begin
                    w_nxt = d_we ? DWR : DRD;
                end
            end
            FETCH:    w_nxt = DONE;
            DRD, DWR: if (w_last) w_nxt = DONE;
            DONE:     w_nxt = IDLE;
            default:  w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_is_f    <= 1'b0;
            r_is_wr   <= 1'b0;
            r_rd_pend <= 1'b0;
            r_left    <= 2'd0;
            r_m_ai    <= '0;
            r_m_vi    <= 8'h00;
            r_f_vo    <= 8'h00;
            r_wsh     <= 24'h0;
            r_acc     <= 24'h0;
            r_d_vo    <= 32'h0;
        end else begin
            r_state   <= w_nxt;
            r_rd_pend <= (r_state == DRD);
            // Read data lags its address by one cycle; shift it in as it lands.
            if (r_rd_pend) begin
                r_acc <= w_ld[23:0];
            end
            case (r_state)
                IDLE: begin
                    if (w_gnt_f) begin
                        r_is_f  <= 1'b1;
                        r_is_wr <= 1'b0;
                        r_m_ai  <= f_ai;
                        r_left  <= 2'd0;
                    end else if (w_gnt_d) begin
                        r_is_f  <= 1'b0;
                        r_is_wr <= d_we;
                        r_m_ai  <= d_ai;
                        r_left  <= w_glast;
                        r_acc   <= 24'h0;
                        if (d_we) begin
                            r_m_vi <= w_sv_al[31:24];
                            r_wsh  <= w_sv_al[23:0];
                        end
                    end
                end
                DRD, DWR: begin
                    if (!w_last) begin
                        r_left <= r_left - 2'd1;
                        r_m_ai <= r_m_ai + IU_W'(1);
                        if (r_is_wr) begin
                            r_m_vi <= r_wsh[23:16];
                            r_wsh  <= {r_wsh[15:0], 8'h00};
                        end
                    end
                end
                DONE: begin
                    if (r_is_f) begin
                        r_f_vo <= m_vo;
                    end else if (!r_is_wr) begin
                        r_d_vo <= w_ld;
                    end
                end
                default: ;
            endcase
        end
    end

    assign m_we  = (r_state == DWR);
    assign busy  = (r_state != IDLE);
    assign m_ai  = r_m_ai;
    assign m_vi  = r_m_vi;
    assign f_ack = (r_state == DONE) &&  r_is_f;
    assign d_ack = (r_state == DONE) && !r_is_f;
    assign f_vo  = f_ack ? m_vo : r_f_vo;
    assign d_vo  = (d_ack && !r_is_wr) ? w_ld : r_d_vo;
endmodule

// File: tb/tb_ej32_mseq.sv
// Directed bench for ej32_mseq: vector table of single transactions plus hand-written corner sequences.
module tb_ej32_mseq;
    import ej32_pkg::*;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            f_req = 1'b0;
    logic [IU_W-1:0] f_ai = '0;
    logic            f_ack;
    logic [7:0]      f_vo;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [1:0]      d_len = 2'b00;
    logic [IU_W-1:0] d_ai = '0;
    logic [31:0]     d_vi = 32'h0;
    logic            d_ack;
    logic [31:0]     d_vo;
    logic            m_we;
    logic [IU_W-1:0] m_ai;
    logic [7:0]      m_vi;
    logic [7:0]      m_vo = 8'h00;
    logic            busy;

    int n_chk = 0;
    int n_fail = 0;

    ej32_mseq dut (
        .clk(clk), .rst(rst),
        .f_req(f_req), .f_ai(f_ai), .f_ack(f_ack), .f_vo(f_vo),
        .d_req(d_req), .d_we(d_we), .d_len(d_len), .d_ai(d_ai), .d_vi(d_vi),
        .d_ack(d_ack), .d_vo(d_vo),
        .m_we(m_we), .m_ai(m_ai), .m_vi(m_vi), .m_vo(m_vo), .busy(busy)
    );

    always #5 clk = ~clk;

    // Byte memory with synchronous read, a bench-side poke port and a write log.
    logic [7:0]      mem [0:(1<<IU_W)-1];
    logic            pk_en = 1'b0;
    logic [IU_W-1:0] pk_a = '0;
    logic [7:0]      pk_d = 8'h00;
    logic [IU_W-1:0] wl_a [$];
    logic [7:0]      wl_d [$];
    int              wl_c [$];
    int              cyc = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (pk_en) begin
            mem[pk_a] <= pk_d;
        end else if (m_we) begin
            mem[m_ai] <= m_vi;
            wl_a.push_back(m_ai);
            wl_d.push_back(m_vi);
            wl_c.push_back(cyc);
        end
        m_vo <= mem[m_ai];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic poke(input logic [IU_W-1:0] a, input logic [7:0] d);
        pk_en = 1'b1;
        pk_a  = a;
        pk_d  = d;
        @(posedge clk); #1;
        pk_en = 1'b0;
    endtask

    logic [IU_W-1:0] tr [8];
    int              tr_n;

    // Called at posedge+1 with the DUT idle; returns at posedge+1 of the ack cycle.
    task automatic do_txn(input logic isf, input logic we, input logic [1:0] len,
                          input logic [IU_W-1:0] a, input logic [31:0] vi,
                          output int lat, output logic [31:0] vo, output int we_cnt);
        lat = -1;
        vo = 32'h0;
        we_cnt = 0;
        tr_n = 0;
        if (isf) begin
            f_req = 1'b1; f_ai = a;
        end else begin
            d_req = 1'b1; d_we = we; d_len = len; d_ai = a; d_vi = vi;
        end
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                // Drop the request and scramble operands: neither may disturb the transfer.
                f_req = 1'b0; d_req = 1'b0;
                f_ai = ~a; d_ai = ~a; d_vi = ~vi; d_len = ~len; d_we = ~we;
            end
            if (m_we) we_cnt++;
            if (isf ? f_ack : d_ack) begin
                lat = c;
                vo = isf ? {24'h0, f_vo} : d_vo;
                break;
            end
            if (tr_n < 8) begin
                tr[tr_n] = m_ai;
                tr_n++;
            end
        end
    endtask

    typedef struct {
        logic            isf;
        logic            we;
        logic [1:0]      len;
        logic [IU_W-1:0] a;
        logic [31:0]     vi;
        logic [31:0]     exp_vo;
        int              exp_lat;
        int              exp_we;
    } vec_t;

    localparam int NV = 12;
    vec_t vt [NV];

    initial begin
        int          lat, wc, base, nack;
        logic [31:0] vo;
        string       exp_seq;
        logic [7:0]  got;

        vt[0]  = '{1'b1, 1'b0, 2'b00, 16'h0010, 32'h0,        32'h000000A5, 2, 0};
        vt[1]  = '{1'b0, 1'b0, 2'b10, 16'h0020, 32'h0,        32'h12345678, 5, 0};
        vt[2]  = '{1'b0, 1'b0, 2'b01, 16'h0022, 32'h0,        32'h00005678, 3, 0};
        vt[3]  = '{1'b0, 1'b0, 2'b00, 16'h0021, 32'h0,        32'h00000034, 2, 0};
        vt[4]  = '{1'b0, 1'b0, 2'b01, 16'h0040, 32'h0,        32'h0000BEEF, 3, 0};
        vt[5]  = '{1'b0, 1'b1, 2'b10, 16'h0050, 32'hDEADBEEF, 32'h0,        5, 4};
        vt[6]  = '{1'b0, 1'b0, 2'b11, 16'h0050, 32'h0,        32'hDEADBEEF, 5, 0};
        vt[7]  = '{1'b1, 1'b0, 2'b00, 16'h0053, 32'h0,        32'h000000EF, 2, 0};
        vt[8]  = '{1'b0, 1'b1, 2'b00, 16'h0060, 32'h123456C3, 32'h0,        2, 1};
        vt[9]  = '{1'b0, 1'b0, 2'b00, 16'h0060, 32'h0,        32'h000000C3, 2, 0};
        vt[10] = '{1'b1, 1'b0, 2'b00, 16'h0041, 32'h0,        32'h000000EF, 2, 0};
        vt[11] = '{1'b0, 1'b0, 2'b01, 16'h0051, 32'h0,        32'h0000ADBE, 3, 0};

        // Reset values, and no grant while reset is held.
        f_req = 1'b1; f_ai = 16'h0010;
        #3;
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_f_ack", 32'(f_ack), 32'd0);
        chk("rst_d_ack", 32'(d_ack), 32'd0);
        chk("rst_m_we",  32'(m_we),  32'd0);
        chk("rst_m_ai",  32'(m_ai),  32'd0);
        chk("rst_m_vi",  32'(m_vi),  32'd0);
        chk("rst_f_vo",  32'(f_vo),  32'd0);
        chk("rst_d_vo",  d_vo,       32'd0);
        @(posedge clk); #1;
        chk("rst_hold_busy", 32'(busy), 32'd0);
        #2 rst = 1'b1;
        #1 chk("rst_release_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        chk("first_grant_busy", 32'(busy), 32'd1);
        f_req = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("first_fetch_idle", 32'(busy), 32'd0);

        poke(16'h0010, 8'hA5);
        poke(16'h0020, 8'h12);
        poke(16'h0021, 8'h34);
        poke(16'h0022, 8'h56);
        poke(16'h0023, 8'h78);
        poke(16'hFFFE, 8'h11);
        poke(16'hFFFF, 8'h22);
        poke(16'h0000, 8'h33);
        poke(16'h0001, 8'h44);

        // Halfword store: MS byte first, consecutive cycles.
        base = wl_a.size();
        do_txn(1'b0, 1'b1, 2'b01, 16'h0040, 32'hCAFEBEEF, lat, vo, wc);
        chk("hst_lat", 32'(lat), 32'd3);
        chk("hst_nwr", 32'(wl_a.size() - base), 32'd2);
        if (wl_a.size() >= base + 2) begin
            chk("hst_a0", 32'(wl_a[base]),   32'h0040);
            chk("hst_d0", 32'(wl_d[base]),   32'h00BE);
            chk("hst_a1", 32'(wl_a[base+1]), 32'h0041);
            chk("hst_d1", 32'(wl_d[base+1]), 32'h00EF);
            chk("hst_gap", 32'(wl_c[base+1] - wl_c[base]), 32'd1);
        end
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            do_txn(vt[i].isf, vt[i].we, vt[i].len, vt[i].a, vt[i].vi, lat, vo, wc);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vt[i].exp_lat));
            chk($sformatf("vec%0d_we", i), 32'(wc), 32'(vt[i].exp_we));
            if (!vt[i].we) chk($sformatf("vec%0d_vo", i), vo, vt[i].exp_vo);
            @(posedge clk); #1;
        end

        // Address wrap at the top of the space, then m_ai holds when idle.
        do_txn(1'b0, 1'b0, 2'b10, 16'hFFFE, 32'h0, lat, vo, wc);
        chk("wrap_lat", 32'(lat), 32'd5);
        chk("wrap_vo",  vo,       32'h11223344);
        chk("wrap_n",   32'(tr_n), 32'd4);
        chk("wrap_a0",  32'(tr[0]), 32'hFFFE);
        chk("wrap_a1",  32'(tr[1]), 32'hFFFF);
        chk("wrap_a2",  32'(tr[2]), 32'h0000);
        chk("wrap_a3",  32'(tr[3]), 32'h0001);
        @(posedge clk); #1;
        chk("idle_m_ai_hold", 32'(m_ai), 32'h0001);
        chk("idle_busy",      32'(busy), 32'd0);

        // Contention from a fresh reset; d_req drops after the fourth ack.
        rst = 1'b0;
        #2 rst = 1'b1;
`ifdef MSEQ_RR_EN
        exp_seq = "FDFDF";
`else
        exp_seq = "DDDDF";
`endif
        f_ai = 16'h0010; d_ai = 16'h0020; d_len = 2'b00; d_we = 1'b0;
        f_req = 1'b1; d_req = 1'b1;
        nack = 0;
        for (int c = 0; c < 60 && nack < 5; c++) begin
            @(posedge clk); #1;
            if (f_ack || d_ack) begin
                got = f_ack ? 8'h46 : 8'h44;
                chk($sformatf("contend_%0d", nack), 32'(got), 32'(exp_seq[nack]));
                if (f_ack) chk($sformatf("contend_fvo_%0d", nack), 32'(f_vo), 32'h00A5);
                else       chk($sformatf("contend_dvo_%0d", nack), d_vo, 32'h00000012);
                nack++;
                if (nack == 4) d_req = 1'b0;
            end
        end
        chk("contend_cnt", 32'(nack), 32'd5);
        f_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // Reset during the second write cycle of a word store.
        base = wl_a.size();
        d_req = 1'b1; d_we = 1'b1; d_len = 2'b10; d_ai = 16'h0070; d_vi = 32'h01020304;
        @(posedge clk); #1;
        d_req = 1'b0;
        chk("rs_c1_we", 32'(m_we), 32'd1);
        chk("rs_c1_ai", 32'(m_ai), 32'h0070);
        chk("rs_c1_vi", 32'(m_vi), 32'h0001);
        @(posedge clk); #1;
        chk("rs_c2_we", 32'(m_we), 32'd1);
        chk("rs_c2_vi", 32'(m_vi), 32'h0002);
        rst = 1'b0;
        #1;
        chk("rs_async_we", 32'(m_we),  32'd0);
        chk("rs_busy",     32'(busy),  32'd0);
        chk("rs_d_ack",    32'(d_ack), 32'd0);
        chk("rs_m_ai",     32'(m_ai),  32'd0);
        @(posedge clk); #3;
        rst = 1'b1;
        nack = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (d_ack) nack++;
        end
        chk("rs_no_ack", 32'(nack), 32'd0);
        chk("rs_nwr",    32'(wl_a.size() - base), 32'd1);
        do_txn(1'b0, 1'b0, 2'b00, 16'h0070, 32'h0, lat, vo, wc);
        chk("rs_next_lat", 32'(lat), 32'd2);
        chk("rs_next_vo",  vo,       32'h00000001);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
